jump_unit: RTL and testbench

//  Resolves J/JAL/JR/JALR in the ID stage and issues a registered fetch redirect

---
 rtl/jump_pkg.sv | 16 +
 rtl/jump_if.sv | 41 ++++
 rtl/jump_ras.sv | 45 ++++
 rtl/jump_unit.sv | 170 +++++++++++++++++
 tb/tb_jump_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/jump_pkg.sv
// Shared decode constants and FSM encoding for the ID-stage jump resolver.
package jump_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RS = 2'd1,
        VERIFY  = 2'd2
    } jump_state_t;

endpackage

// File: rtl/jump_if.sv
// ID-stage <-> jump unit bundle: decoded fields in, redirect/link/verify results out.
interface jump_if #(
    parameter int ADDR_W = 32
) ();

    logic              id_valid;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rs_idx;
    logic [4:0]        rd_idx;
    logic [25:0]       instr_index;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] rs_data;
    logic              rs_ready;
    logic              verify_valid;
    logic [ADDR_W-1:0] verify_data;
    logic              flush;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              link_we;
    logic [4:0]        link_idx;
    logic [ADDR_W-1:0] link_data;
    logic              mispredict;
    logic              ras_empty;

    modport master (
        output id_valid, op, funct, rs_idx, rd_idx, instr_index, pc_plus4,
               rs_data, rs_ready, verify_valid, verify_data, flush,
        input  stall, redirect_valid, redirect_pc, link_we, link_idx,
               link_data, mispredict, ras_empty
    );

    modport slave (
        input  id_valid, op, funct, rs_idx, rd_idx, instr_index, pc_plus4,
               rs_data, rs_ready, verify_valid, verify_data, flush,
        output stall, redirect_valid, redirect_pc, link_we, link_idx,
               link_data, mispredict, ras_empty
    );

endinterface

// File: rtl/jump_ras.sv
// Circular return-address stack; a push when full silently drops the oldest entry.
module jump_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(RAS_DEPTH));
    assign top   = mem[ptr - PTR_W'(1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (!full) cnt <= cnt + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - PTR_W'(1);
            cnt <= cnt - CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; cnt gates every read, so stale contents are never used.
    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= push_data;
    end

endmodule

// File: rtl/jump_unit.sv
// ID-stage J/JAL/JR/JALR resolver with registered redirect, link write and RAS-predicted JR $31.
module jump_unit
    import jump_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4,
    parameter int RAS_EN    = 1,
    parameter int LINK_REG  = 31
) (
    input logic   clk,
    input logic   rst_n,
    jump_if.slave bus
);

    jump_state_t       state, state_nxt;
    logic              is_j, is_jal, is_jr, is_jalr, is_direct, is_jump, rs_is_link;
    logic              can_predict, resolve, predict, push, pop;
    logic [ADDR_W-1:0] target_j, ras_top, pred_q;
    logic              ras_empty, ras_full;

    logic              nxt_rv, nxt_lw, nxt_mp;
    logic [ADDR_W-1:0] nxt_pc, nxt_ld;
    logic [4:0]        nxt_li;
    logic              redirect_valid_q, link_we_q, mispredict_q;
    logic [ADDR_W-1:0] redirect_pc_q, link_data_q;
    logic [4:0]        link_idx_q;

    assign is_j        = (bus.op == OP_J);
    assign is_jal      = (bus.op == OP_JAL);
    assign is_jr       = (bus.op == OP_SPECIAL) && (bus.funct == FN_JR);
    assign is_jalr     = (bus.op == OP_SPECIAL) && (bus.funct == FN_JALR);
    assign is_direct   = is_j || is_jal;
    assign is_jump     = is_direct || is_jr || is_jalr;
    assign rs_is_link  = (bus.rs_idx == 5'(LINK_REG));
    assign can_predict = (RAS_EN != 0) && is_jr && rs_is_link && !ras_empty;

    // Region bits come from PC+4; the low 28 bits are the word-aligned index.
    always_comb begin
        target_j       = bus.pc_plus4;
        target_j[27:0] = {bus.instr_index, 2'b00};
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt = state;
        bus.stall = 1'b0;
        resolve   = 1'b0;
        predict   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        nxt_rv    = 1'b0;
        nxt_pc    = redirect_pc_q;
        nxt_lw    = 1'b0;
        nxt_li    = link_idx_q;
        nxt_ld    = link_data_q;
        nxt_mp    = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.id_valid && is_jump) begin
                    if (is_direct || bus.rs_ready) begin
                        resolve = 1'b1;
                    end else if (can_predict) begin
                        predict   = 1'b1;
                        pop       = 1'b1;
                        nxt_rv    = 1'b1;
                        nxt_pc    = ras_top;
                        state_nxt = VERIFY;
                    end else begin
                        bus.stall = 1'b1;
                        state_nxt = WAIT_RS;
                    end
                end
            end
            WAIT_RS: begin
                if (bus.id_valid && bus.rs_ready) begin
                    resolve   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    bus.stall = 1'b1;
                end
            end
            VERIFY: begin
                // Only one speculation may be outstanding at a time.
                bus.stall = bus.id_valid && is_jump;
                if (bus.verify_valid) begin
                    state_nxt = IDLE;
                    if (bus.verify_data != pred_q) begin
                        nxt_rv = 1'b1;
                        nxt_pc = bus.verify_data;
                        nxt_mp = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (resolve) begin
            nxt_rv = 1'b1;
            nxt_pc = is_direct ? target_j : bus.rs_data;
            if (is_jal || is_jalr) begin
                nxt_lw = 1'b1;
                nxt_li = is_jal ? 5'(LINK_REG) : bus.rd_idx;
                nxt_ld = bus.pc_plus4;
                push   = 1'b1;
            end
            pop = is_jr && rs_is_link;
        end

        // Flush cancels everything decided above; the RAS is left as-is.
        if (bus.flush) begin
            state_nxt = IDLE;
            bus.stall = 1'b0;
            predict   = 1'b0;
            push      = 1'b0;
            pop       = 1'b0;
            nxt_rv    = 1'b0;
            nxt_lw    = 1'b0;
            nxt_mp    = 1'b0;
        end
    end

    jump_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push && (RAS_EN != 0)),
        .pop       (pop && (RAS_EN != 0)),
        .push_data (bus.pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            link_we_q        <= 1'b0;
            link_idx_q       <= '0;
            link_data_q      <= '0;
            mispredict_q     <= 1'b0;
            pred_q           <= '0;
        end else begin
            state            <= state_nxt;
            redirect_valid_q <= nxt_rv;
            redirect_pc_q    <= nxt_pc;
            link_we_q        <= nxt_lw;
            link_idx_q       <= nxt_li;
            link_data_q      <= nxt_ld;
            mispredict_q     <= nxt_mp;
            if (predict) pred_q <= ras_top;
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.link_we        = link_we_q;
    assign bus.link_idx       = link_idx_q;
    assign bus.link_data      = link_data_q;
    assign bus.mispredict     = mispredict_q;
    assign bus.ras_empty      = ras_empty;

    a_ras_sane: assert property (@(posedge clk) disable iff (!rst_n) !(ras_full && ras_empty));

endmodule

// File: tb/tb_jump_unit.sv
// Directed scoreboard bench for jump_unit: inputs change on the falling edge, results are checked one edge later.
module tb_jump_unit;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jump_if #(.ADDR_W(ADDR_W)) bus ();

    jump_unit #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (4),
        .RAS_EN    (1),
        .LINK_REG  (31)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        lw;
        logic [4:0]  li;
        logic [31:0] ld;
        logic        mp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t none();
        exp_t e = '{rv: 1'b0, pc: '0, lw: 1'b0, li: '0, ld: '0, mp: 1'b0};
        return e;
    endfunction

    function automatic exp_t redir(input logic [31:0] pc);
        exp_t e = none();
        e.rv = 1'b1;
        e.pc = pc;
        return e;
    endfunction

    function automatic exp_t link(input logic [31:0] pc, input logic [4:0] li, input logic [31:0] ld);
        exp_t e = redir(pc);
        e.lw = 1'b1;
        e.li = li;
        e.ld = ld;
        return e;
    endfunction

    function automatic exp_t mis(input logic [31:0] pc);
        exp_t e = redir(pc);
        e.mp = 1'b1;
        return e;
    endfunction

    // Called at a falling edge with inputs already set: checks stall, then the registered result.
    task automatic step(input exp_t e, input logic exp_stall, input string tag);
        exp_t want;
        #1;
        chk({tag, ".stall"}, 32'(bus.stall), 32'(exp_stall));
        sb.push_back(e);
        @(negedge clk);
        want = sb.pop_front();
        chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(want.rv));
        if (want.rv) chk({tag, ".redirect_pc"}, bus.redirect_pc, want.pc);
        chk({tag, ".link_we"}, 32'(bus.link_we), 32'(want.lw));
        if (want.lw) begin
            chk({tag, ".link_idx"}, 32'(bus.link_idx), 32'(want.li));
            chk({tag, ".link_data"}, bus.link_data, want.ld);
        end
        chk({tag, ".mispredict"}, 32'(bus.mispredict), 32'(want.mp));
    endtask

    task automatic put(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rd, input logic [25:0] idx, input logic [31:0] pc4,
                       input logic [31:0] rsd, input logic rdy);
        bus.id_valid     = 1'b1;
        bus.op           = op;
        bus.funct        = fn;
        bus.rs_idx       = rs;
        bus.rd_idx       = rd;
        bus.instr_index  = idx;
        bus.pc_plus4     = pc4;
        bus.rs_data      = rsd;
        bus.rs_ready     = rdy;
        bus.verify_valid = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic nop();
        bus.id_valid     = 1'b0;
        bus.rs_ready     = 1'b0;
        bus.verify_valid = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic put_j(input logic [31:0] pc4, input logic [25:0] idx);
        put(6'b000010, 6'd0, 5'd0, 5'd0, idx, pc4, 32'h0, 1'b0);
    endtask

    task automatic put_jal(input logic [31:0] pc4, input logic [25:0] idx);
        put(6'b000011, 6'd0, 5'd0, 5'd0, idx, pc4, 32'h0, 1'b0);
    endtask

    task automatic put_jr(input logic [4:0] rs, input logic [31:0] rsd, input logic rdy);
        put(6'b000000, 6'b001000, rs, 5'd0, 26'd0, 32'h0000_0f00, rsd, rdy);
    endtask

    task automatic put_jalr(input logic [4:0] rs, input logic [4:0] rd, input logic [31:0] pc4,
                            input logic [31:0] rsd, input logic rdy);
        put(6'b000000, 6'b001001, rs, rd, 26'd0, pc4, rsd, rdy);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'd0);
        chk({tag, ".redirect_pc"}, bus.redirect_pc, 32'd0);
        chk({tag, ".link_we"}, 32'(bus.link_we), 32'd0);
        chk({tag, ".link_idx"}, 32'(bus.link_idx), 32'd0);
        chk({tag, ".link_data"}, bus.link_data, 32'd0);
        chk({tag, ".mispredict"}, 32'(bus.mispredict), 32'd0);
        chk({tag, ".ras_empty"}, 32'(bus.ras_empty), 32'd1);
    endtask

    initial begin
        put(6'd0, 6'd0, 5'd0, 5'd0, 26'd0, 32'h0, 32'h0, 1'b0);
        nop();
        bus.verify_data = 32'h0;
        repeat (2) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;

        // J: region bits from PC+4, single-cycle pulse, no link
        put_j(32'h4000_0104, 26'h000_0040);
        step(redir(32'h4000_0100), 1'b0, "t1_j");
        nop();
        step(none(), 1'b0, "t1_pulse_end");
        chk("t1_ras_empty", 32'(bus.ras_empty), 32'd1);

        // JAL then predicted JR $31, verified correct
        put_jal(32'h0000_0088, 26'h000_0100);
        step(link(32'h0000_0400, 5'd31, 32'h0000_0088), 1'b0, "t2_jal");
        chk("t2_ras_nonempty", 32'(bus.ras_empty), 32'd0);
        put_jr(5'd31, 32'hdead_beef, 1'b0);
        step(redir(32'h0000_0088), 1'b0, "t2_jr_pred");
        nop();
        bus.verify_valid = 1'b1;
        bus.verify_data  = 32'h0000_0088;
        step(none(), 1'b0, "t2_verify_ok");

        // Predicted JR $31 resolved wrong; a JR waiting in ID is held meanwhile
        put_jal(32'h0000_0088, 26'h000_0100);
        step(link(32'h0000_0400, 5'd31, 32'h0000_0088), 1'b0, "t3_jal");
        put_jr(5'd31, 32'h0, 1'b0);
        step(redir(32'h0000_0088), 1'b0, "t3_jr_pred");
        put_jr(5'd31, 32'h0, 1'b0);
        step(none(), 1'b1, "t3_hold_in_verify");
        put_jr(5'd31, 32'h0, 1'b0);
        bus.verify_valid = 1'b1;
        bus.verify_data  = 32'h0000_0090;
        step(mis(32'h0000_0090), 1'b1, "t3_mispredict");
        nop();
        step(none(), 1'b0, "t3_pulse_end");

        // JALR waits three cycles for rs, then redirects and links rd
        put_jalr(5'd7, 5'd5, 32'h0000_0200, 32'h0000_1234, 1'b0);
        step(none(), 1'b1, "t4_wait1");
        step(none(), 1'b1, "t4_wait2");
        step(none(), 1'b1, "t4_wait3");
        bus.rs_ready = 1'b1;
        step(link(32'h0000_1234, 5'd5, 32'h0000_0200), 1'b0, "t4_jalr");
        nop();
        step(none(), 1'b0, "t4_pulse_end");

        // Overflow the 4-entry RAS, then drain it with predicted returns
        for (int i = 1; i <= 5; i++) begin
            put_jal(32'(i * 16), 26'd0);
            step(link(32'h0, 5'd31, 32'(i * 16)), 1'b0, "t5_jal");
        end
        for (int i = 0; i < 4; i++) begin
            put_jr(5'd31, 32'h0, 1'b0);
            step(redir(32'(80 - i * 16)), 1'b0, "t5_jr_pred");
            nop();
            bus.verify_valid = 1'b1;
            bus.verify_data  = 32'(80 - i * 16);
            step(none(), 1'b0, "t5_verify");
        end
        chk("t5_ras_drained", 32'(bus.ras_empty), 32'd1);
        put_jr(5'd31, 32'h0, 1'b0);
        step(none(), 1'b1, "t5_jr_empty_stall");

        // Flush out of WAIT_RS, then a J must be taken immediately
        bus.flush = 1'b1;
        step(none(), 1'b0, "t6_flush_wait_rs");
        put_j(32'h4000_0104, 26'h000_0080);
        step(redir(32'h4000_0200), 1'b0, "t6_idle_after_flush");
        put_j(32'h4000_0104, 26'h000_0080);
        bus.flush = 1'b1;
        step(none(), 1'b0, "t6_flush_with_j");
        nop();
        step(none(), 1'b0, "t6_after_flush_j");

        // Asynchronous reset while a prediction is outstanding
        put_jal(32'h0000_0300, 26'd0);
        step(link(32'h0, 5'd31, 32'h0000_0300), 1'b0, "t6_jal");
        put_jr(5'd31, 32'h0, 1'b0);
        step(redir(32'h0000_0300), 1'b0, "t6_jr_pred");
        nop();
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("t6_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        put_j(32'h4000_0104, 26'h000_0040);
        step(redir(32'h4000_0100), 1'b0, "t6_idle_after_reset");
        nop();
        step(none(), 1'b0, "t6_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
